// File: rtl/tinker_alu_pkg.sv
// Shared definitions for the ALU dispatcher: op codes, FSM states and the
// per-op latency lookup used when an operation is accepted.
package tinker_alu_pkg;

   localparam logic [5:0] OP_ADD       = 6'd0;
   localparam logic [5:0] OP_SUB       = 6'd1;
   localparam logic [5:0] OP_MUL       = 6'd2;
   localparam logic [5:0] OP_DIV       = 6'd3;
   localparam logic [5:0] OP_LOGIC_AND = 6'd4;
   localparam logic [5:0] OP_LOGIC_OR  = 6'd5;
   localparam logic [5:0] OP_LOGIC_NOR = 6'd6;
   localparam logic [5:0] OP_LOGIC_XOR = 6'd7;
   localparam logic [5:0] OP_SHR       = 6'd8;
   localparam logic [5:0] OP_SHL       = 6'd9;
   localparam logic [5:0] OP_BYPASS    = 6'd63;

   // Wide enough for any realistic unit latency; the load value is LAT-1.
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_MUL  = 2'd1,
      SRC_DIV  = 2'd2,
      SRC_NONE = 2'd3
   } src_e;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             illegal;
   } lat_t;

   function automatic logic op_is_illegal(input logic [5:0] op);
      return (op > OP_SHL) && (op != OP_BYPASS);
   endfunction

   function automatic lat_t op_latency(input logic [5:0] op,
                                       input int         mul_lat,
                                       input int         div_lat);
      lat_t r;
      r.cnt     = '0;
      r.illegal = op_is_illegal(op);
      if (op == OP_MUL) begin
         r.cnt = CNT_W'(mul_lat - 1);
      end else if (op == OP_DIV) begin
         r.cnt = CNT_W'(div_lat - 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_dispatch.sv
// Single-issue dispatcher: holds one decoded op, feeds the execution units,
// waits the unit latency and buffers the result for writeback.
module alu_dispatch
   import tinker_alu_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int TAG_W   = 5,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [5:0]        alu_cont,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mul_result,
   input  logic [DATA_W-1:0] div_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic              busy
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   src_e              src_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [5:0]        cont_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] out_data_q;
   logic [TAG_W-1:0]  out_tag_q;
   logic              out_err_q;
   logic              out_valid_q;

   logic              accept;
   lat_t              lat_d;
   src_e              src_d;
   logic [DATA_W-1:0] result_d;

   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      lat_d = op_latency(in_op, MUL_LAT, DIV_LAT);
      src_d = SRC_ALU;
      if (lat_d.illegal) begin
         src_d = SRC_NONE;
      end else if (in_op == OP_MUL) begin
         src_d = SRC_MUL;
      end else if (in_op == OP_DIV) begin
         src_d = SRC_DIV;
      end
   end

   // Unit select is latched at accept, so capture never re-decodes alu_cont.
   always_comb begin
      result_d = '0;
      unique case (src_q)
         SRC_ALU:  result_d = alu_result;
         SRC_MUL:  result_d = mul_result;
         SRC_DIV:  result_d = div_result;
         SRC_NONE: result_d = '0;
         default:  result_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         src_q       <= SRC_ALU;
         a_q         <= '0;
         b_q         <= '0;
         cont_q      <= OP_BYPASS;
         tag_q       <= '0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // Operands stay put between accepts: the unit pipelines never stall.
         if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            cont_q <= in_op;
            tag_q  <= in_tag;
            src_q  <= src_d;
            cnt_q  <= lat_d.cnt;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  out_data_q  <= result_d;
                  out_tag_q   <= tag_q;
                  out_err_q   <= (src_q == SRC_NONE);
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= accept ? ST_EXEC : ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_cont  = cont_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side counterpart to the processor's execution units. Accepts decoded operations from the decode stage over a valid/ready handshake and drives operands and the 6-bit control code to the combinational ALU, the 3-stage multiplier and the 8-stage divider. It waits the fixed latency of the selected unit, captures the result, and returns it with its destination tag to writeback over a second valid/ready handshake. There is one operation in flight at a time, and the output is buffered until writeback accepts it.

## Interface
- DATA_W, 64: operand/result width
- TAG_W, 5: destination register tag width
- MUL_LAT, 3: multiplier result latency in clock edges
- DIV_LAT, 8: divider result latency in clock edges
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode presents an operation
- in_ready  out  1  dispatcher can accept
- in_op  in  6  control code: 0 add, 1 sub, 2 mul, 3 div, 4–7 logic, 8–9 shift, 63 bypass
- in_a, in_b  in  DATA_W  operands
- in_tag  in  TAG_W  destination tag
- alu_a, alu_b  out  DATA_W  registered operands to all execution units
- alu_cont  out  6  registered control code
- alu_result  in  DATA_W  combinational ALU result
- mul_result, div_result  in  DATA_W  pipelined unit outputs
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_data  out  DATA_W  result
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  op code was illegal (10–62)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, DONE.
- Accept condition: in_valid && in_ready. in_ready = (IDLE) || (DONE && out_ready).
- On accept:
  - Load alu_a, alu_b, alu_cont and tag register.
  - Load the latency counter: 0 for codes 0–1, 4–9, 63 and illegal codes; MUL_LAT−1 for 2; DIV_LAT−1 for 3.
  - Go to EXEC.
- EXEC:
  - If counter != 0, decrement.
  - If counter == 0, capture the result into out_data: alu_result for ALU codes, mul_result for 2, div_result for 3, 0 for illegal codes. Set out_err for illegal codes. Go to DONE.
- DONE:
  - out_valid = 1. out_data, out_tag and out_err are held stable until out_ready.
  - If out_ready and a new accept occur in the same cycle, go directly to EXEC with the new operation.
  - If out_ready with no accept, go to IDLE.
- Operand registers hold their value from accept until the next accept. The execution pipelines never stall, so operands must stay stable for the full latency.
- Arithmetic is performed by the units; the dispatcher does no width conversion. Results are truncated to DATA_W by the units.

## Timing
- Reset (async assert, sync release):
  - State IDLE; out_valid = 0, out_data = 0, out_tag = 0, out_err = 0.
  - alu_a = 0, alu_b = 0, alu_cont = 63 (bypass); counter = 0.
  - in_ready = 1 after release.
- Accept at edge T:
  - Comb/illegal ops: out_valid high after edge T+1.
  - Mul: out_valid high after edge T+MUL_LAT.
  - Div: out_valid high after edge T+DIV_LAT.
- Throughput is one operation per (latency + 1) cycles with out_ready held high. Back-to-back issue from DONE is allowed.
- Reset mid-EXEC or mid-DONE drops the in-flight operation; no out_valid follows.
- in_valid while busy and not in DONE: in_ready = 0. Decode must hold its inputs stable.
- out_ready while out_valid = 0 is ignored.

## Structure
- Shared package tinker_alu_pkg contains:
  - op code localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOGIC_*, OP_SHR, OP_SHL, OP_BYPASS)
  - the state enum
  - function op_latency(op, MUL_LAT, DIV_LAT) returning the counter load value and an illegal flag
- No sub-module. FSM, counter and output register live in alu_dispatch.

## Test plan
- Sub: in_op = 1, a = 10, b = 3, tag = 7, out_ready = 1 → out_valid exactly 1 cycle after accept, out_data = 7, out_tag = 7, out_err = 0.
- Mul latency: in_op = 2, a = 6, b = 7 → out_valid 3 cycles after accept with out_data = 42. in_ready = 0 throughout EXEC.
- Backpressure: Sub result pending with out_ready = 0 for 5 cycles → out_data and out_tag stable. A second op presented meanwhile is accepted only in the cycle out_ready = 1, and its result follows 1 cycle later.
- Illegal op: in_op = 20 → 1 cycle later out_valid = 1, out_err = 1, out_data = 0.
- Reset mid-op: div accepted, rst_n low at cycle 4 → all outputs at reset values immediately, no out_valid after release, and in_ready = 1.
- Back-to-back: 4 alternating XOR (op 7) and bypass (op 63) ops with out_ready = 1 → results in order, one every 2 cycles, with tags matching.
